// File: rtl/mem_pkg.sv
// Shared types for the memory arbiter: access sizes, read-return owner and datapath widths.
// Imported by mem_arb and by anything that drives or decodes its size field.
package mem_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_FETCH,
        OWN_DATA
    } owner_e;

    // A data request with the write strobe set never produces a read return.
    function automatic logic data_reads(input logic r, input logic w);
        return r & ~w;
    endfunction

endpackage

// File: rtl/mem_arb.sv
// Two-requester arbiter (fetch, data) in front of one synchronous memory port.
// Data normally wins; a bounded starvation counter forces fetch through.
module mem_arb #(
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rstn,

    input  logic        f_r,
    input  logic [1:0]  f_sz,
    input  logic [31:0] f_addr,
    output logic        f_busy,
    output logic        f_rvalid,
    output logic [31:0] f_rdata,

    input  logic        d_r,
    input  logic        d_w,
    input  logic [1:0]  d_sz,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_busy,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,

    output logic        m_r,
    output logic        m_w,
    output logic [1:0]  m_sz,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata
);

    import mem_pkg::*;

    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic              f_pend;
    logic              d_pend;
    logic              starve_hit;
    logic              f_gnt;
    logic              d_gnt;
    logic              d_rd;
    logic [CNT_W-1:0]  starve_cnt;
    logic [CNT_W-1:0]  starve_nxt;
    owner_e            own_nxt;
    owner_e            own_p1;
    logic [DATA_W-1:0] f_hold_p1;
    logic [DATA_W-1:0] d_hold_p1;

    // Stage p0: grant decision and memory command, all combinational.
    always_comb begin
        f_pend     = rstn & f_r;
        d_pend     = rstn & (d_r | d_w);
        starve_hit = (starve_cnt == STARVE_LIM);

        f_gnt = f_pend & (~d_pend | starve_hit);
        d_gnt = d_pend & ~f_gnt;
        d_rd  = d_gnt & data_reads(d_r, d_w);

        m_r     = f_gnt | d_rd;
        m_w     = d_gnt & d_w;
        m_sz    = 2'd0;
        m_addr  = '0;
        m_wdata = '0;
        if (f_gnt) begin
            m_sz   = f_sz;
            m_addr = f_addr;
        end else if (d_gnt) begin
            m_sz    = d_sz;
            m_addr  = d_addr;
            m_wdata = d_wdata;
        end

        f_busy = f_pend & ~f_gnt;
        d_busy = d_pend & ~d_gnt;

        own_nxt = OWN_NONE;
        if (f_gnt) begin
            own_nxt = OWN_FETCH;
        end else if (d_rd) begin
            own_nxt = OWN_DATA;
        end

        // Cleared whenever fetch is idle or served; otherwise fetch just lost to data.
        starve_nxt = starve_cnt;
        if (!f_r || f_gnt) begin
            starve_nxt = '0;
        end else if (d_gnt) begin
            starve_nxt = starve_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_nxt;
        end
    end

    // Stage p1: the read issued last cycle returns; route it to its owner.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            own_p1    <= OWN_NONE;
            f_hold_p1 <= '0;
            d_hold_p1 <= '0;
        end else begin
            own_p1 <= own_nxt;
            if (own_p1 == OWN_FETCH) begin
                f_hold_p1 <= m_rdata;
            end
            if (own_p1 == OWN_DATA) begin
                d_hold_p1 <= m_rdata;
            end
        end
    end

    always_comb begin
        f_rvalid = (own_p1 == OWN_FETCH);
        d_rvalid = (own_p1 == OWN_DATA);
        f_rdata  = f_rvalid ? m_rdata : f_hold_p1;
        d_rdata  = d_rvalid ? m_rdata : d_hold_p1;
    end

endmodule
